// File: rtl/dl_shift_pkg.sv
// Shared types and width helpers for the pipelined shift unit.
package dl_shift_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL  = 2'b00,
      SHIFT_SRL  = 2'b01,
      SHIFT_SRA  = 2'b10,
      SHIFT_PASS = 2'b11
   } shift_op_t;

   // Width of a shift amount able to address every bit of an n-bit operand.
   function automatic int shift_bits(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dl_shift_pipe_if.sv
// Operand/result bus of the shift pipe: request side (in_*) and result side (out_*).
// Handshake: a transfer happens on a rising edge where valid && ready; the sender
// holds its payload stable while valid && !ready, and valid never waits on ready.
interface dl_shift_pipe_if
   import dl_shift_pkg::*;
#(
   parameter int NUM_BITS = 32,
   parameter int TAG_BITS = 4
) ();

   localparam int NUM_SHIFT_BITS = shift_bits(NUM_BITS);

   logic                      in_valid;
   logic                      in_ready;
   shift_op_t                 in_op;
   logic [NUM_BITS-1:0]       in_data;
   logic [NUM_SHIFT_BITS-1:0] in_shamt;
   logic [TAG_BITS-1:0]       in_tag;

   logic                      out_valid;
   logic                      out_ready;
   logic [NUM_BITS-1:0]       out_data;
   logic [TAG_BITS-1:0]       out_tag;
   logic                      out_zero;

   modport master (
      output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_zero
   );

   modport slave (
      input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_zero
   );

endinterface

// File: rtl/dl_shift_core.sv
// Combinational barrel shifter: logical left/right, arithmetic right, or pass-through.
module dl_shift_core
   import dl_shift_pkg::*;
#(
   parameter int NUM_BITS       = 32,
   parameter int NUM_SHIFT_BITS = shift_bits(NUM_BITS)
) (
   input  shift_op_t                 op,
   input  logic [NUM_BITS-1:0]       data,
   input  logic [NUM_SHIFT_BITS-1:0] shamt,
   output logic [NUM_BITS-1:0]       result
);

   always_comb begin
      result = data;
      unique case (op)
         SHIFT_SLL:  result = data << shamt;
         SHIFT_SRL:  result = data >> shamt;
         SHIFT_SRA:  result = $unsigned($signed(data) >>> shamt);
         SHIFT_PASS: result = data;
         default:    result = data;
      endcase
   end

endmodule

// File: rtl/dl_shift_pipe.sv
// Two-stage shift unit: stage 1 registers the request, stage 2 registers the
// shifted result, its tag and a zero flag. Stalls propagate back via in_ready.
module dl_shift_pipe
   import dl_shift_pkg::*;
#(
   parameter int NUM_BITS = 32,
   parameter int TAG_BITS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   dl_shift_pipe_if.slave    bus
);

   localparam int NUM_SHIFT_BITS = shift_bits(NUM_BITS);

   logic                      s1_valid;
   shift_op_t                 s1_op;
   logic [NUM_BITS-1:0]       s1_data;
   logic [NUM_SHIFT_BITS-1:0] s1_shamt;
   logic [TAG_BITS-1:0]       s1_tag;

   logic                      s2_valid;
   logic [NUM_BITS-1:0]       s2_data;
   logic [TAG_BITS-1:0]       s2_tag;
   logic                      s2_zero;

   logic                      s2_adv;
   logic                      s1_adv;
   logic                      in_fire;
   logic [NUM_BITS-1:0]       shift_res;

   // in_ready depends combinationally on out_ready so a full pipe can still
   // take a new op in the same cycle it hands one downstream.
   assign s2_adv       = !s2_valid || bus.out_ready;
   assign s1_adv       = s1_valid && s2_adv;
   assign bus.in_ready = rst_n && (!s1_valid || s2_adv);
   assign in_fire      = bus.in_valid && bus.in_ready;

   dl_shift_core #(
      .NUM_BITS       (NUM_BITS),
      .NUM_SHIFT_BITS (NUM_SHIFT_BITS)
   ) u_core (
      .op     (s1_op),
      .data   (s1_data),
      .shamt  (s1_shamt),
      .result (shift_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= SHIFT_SLL;
         s1_data  <= '0;
         s1_shamt <= '0;
         s1_tag   <= '0;
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_tag   <= '0;
         s2_zero  <= 1'b1;
      end else begin
         if (in_fire) begin
            s1_op    <= bus.in_op;
            s1_data  <= bus.in_data;
            s1_shamt <= bus.in_shamt;
            s1_tag   <= bus.in_tag;
         end
         s1_valid <= in_fire ? 1'b1 : (s1_adv ? 1'b0 : s1_valid);

         if (s1_adv) begin
            s2_data <= shift_res;
            s2_tag  <= s1_tag;
            s2_zero <= (shift_res == '0);
         end
         s2_valid <= s1_adv ? 1'b1 : (bus.out_ready ? 1'b0 : s2_valid);
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.out_data  = s2_data;
   assign bus.out_tag   = s2_tag;
   assign bus.out_zero  = s2_zero;

endmodule

// File: tb/tb_dl_shift_pipe.sv
// Self-checking bench for dl_shift_pipe (8-bit operands, 4-bit tags): directed
// cases plus a randomized stream checked against an arithmetic reference model.
module tb_dl_shift_pipe;
   import dl_shift_pkg::*;

   localparam int NB = 8;
   localparam int TB = 4;
   localparam int W  = NB + TB;

   logic clk;
   logic rst_n;

   dl_shift_pipe_if #(.NUM_BITS(NB), .TAG_BITS(TB)) bus ();

   dl_shift_pipe #(.NUM_BITS(NB), .TAG_BITS(TB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference shift in plain integer arithmetic on an NB-bit value.
   function automatic int ref_shift(input int op, input int d, input int s);
      int p;
      int m;
      p = 1 << s;
      m = 1 << NB;
      case (op)
         0:       return (d * p) % m;
         1:       return d / p;
         2:       return d / p + ((d >= m / 2) ? (m - m / p) : 0);
         default: return d;
      endcase
   endfunction

   logic          hold_prev = 1'b0;
   logic [NB-1:0] prev_data;
   logic [TB-1:0] prev_tag;
   logic          prev_zero;

   // Everything settles between edges, so the negedge sees what the next
   // posedge will act on.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", 32'(bus.out_data), 32'(prev_data));
            check("hold_tag", 32'(bus.out_tag), 32'(prev_tag));
            check("hold_zero", 32'(bus.out_zero), 32'(prev_zero));
         end
         hold_prev = bus.out_valid && !bus.out_ready;
         prev_data = bus.out_data;
         prev_tag  = bus.out_tag;
         prev_zero = bus.out_zero;

         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_out", 32'(bus.out_tag), 32'hFFFF_FFFF);
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               check("sb_tag", 32'(bus.out_tag), 32'(e[W-1:NB]));
               check("sb_data", 32'(bus.out_data), 32'(e[NB-1:0]));
               check("sb_zero", 32'(bus.out_zero), 32'(e[NB-1:0] == '0));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            int r;
            r = ref_shift(int'(bus.in_op), int'(bus.in_data), int'(bus.in_shamt));
            exp_q.push_back({bus.in_tag, NB'(r)});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic set_in(input int op, input int d, input int s, input int t, input logic v);
      bus.in_valid = v;
      bus.in_op    = shift_op_t'(op[1:0]);
      bus.in_data  = NB'(d);
      bus.in_shamt = 3'(s);
      bus.in_tag   = TB'(t);
   endtask

   // One op into an idle pipe with out_ready=1: checks 2-cycle latency.
   task automatic run_one(input int op, input int d, input int s, input int t, input int exp);
      step();
      set_in(op, d, s, t, 1'b1);
      bus.out_ready = 1'b1;
      sample();
      check("one_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      sample();
      check("one_early_valid", 32'(bus.out_valid), 32'd0);
      step();
      sample();
      check("one_valid", 32'(bus.out_valid), 32'd1);
      check("one_data", 32'(bus.out_data), 32'(exp));
      check("one_tag", 32'(bus.out_tag), 32'(t));
      check("one_zero", 32'(bus.out_zero), 32'(exp == 0));
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && n < max_cycles) begin
         step();
         n++;
      end
      step();
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int idx;
      logic acc;
      int sent;
      int cyc;
      logic [NB-1:0] rd;

      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      set_in(0, 0, 0, 0, 1'b0);
      #12;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_tag", 32'(bus.out_tag), 32'd0);
      check("rst_out_zero", 32'(bus.out_zero), 32'd1);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      rst_n = 1'b1;

      // Ops on 0x96, shamt 3, tag 5
      run_one(2, 'h96, 3, 5, 'hF2);
      run_one(1, 'h96, 3, 5, 'h12);
      run_one(0, 'h96, 3, 5, 'hB0);
      run_one(3, 'h96, 3, 5, 'h96);
      // Boundaries
      run_one(2, 'h80, 7, 6, 'hFF);
      run_one(1, 'h80, 7, 7, 'h01);
      run_one(0, 'h01, 7, 8, 'h80);
      run_one(0, 'h80, 1, 9, 'h00);
      for (int op = 0; op < 4; op++) begin
         rd = NB'($urandom_range(0, 255));
         run_one(op, int'(rd), 0, op, int'(rd));
      end

      // Throughput: tags 1..4 back to back, out at cycles 2..5
      for (int c = 0; c < 6; c++) begin
         step();
         bus.out_ready = 1'b1;
         if (c < 4) set_in(1, 'h40 + c, 1, c + 1, 1'b1);
         else bus.in_valid = 1'b0;
         sample();
         if (c < 4) check("tp_in_ready", 32'(bus.in_ready), 32'd1);
         if (c >= 2) begin
            check("tp_valid", 32'(bus.out_valid), 32'd1);
            check("tp_tag", 32'(bus.out_tag), 32'(c - 1));
         end
      end
      drain(10);

      // Backpressure: in_valid held, out_ready low for 4 cycles
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         bus.out_ready = 1'b0;
         set_in(idx % 3, 'hA5 + idx, idx + 1, 10 + idx, 1'b1);
         sample();
         check("bp_in_ready", 32'(bus.in_ready), 32'(c < 2));
         if (bus.in_ready) idx++;
      end
      cyc = 0;
      acc = 1'b0;
      while ((idx < 4 || acc) && cyc < 20) begin
         step();
         if (acc) idx++;
         bus.out_ready = 1'b1;
         if (idx < 4) set_in(idx % 3, 'hA5 + idx, idx + 1, 10 + idx, 1'b1);
         else bus.in_valid = 1'b0;
         sample();
         acc = bus.in_valid && bus.in_ready;
         cyc++;
      end
      check("bp_all_sent", 32'(idx), 32'd4);
      drain(10);

      // Reset mid-operation with both stages full
      for (int c = 0; c < 3; c++) begin
         step();
         bus.out_ready = 1'b0;
         set_in(0, 'h33, 2, 1 + c, 1'b1);
      end
      sample();
      check("mr_full_valid", 32'(bus.out_valid), 32'd1);
      check("mr_full_ready", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("mr_valid_drop", 32'(bus.out_valid), 32'd0);
      check("mr_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      run_one(1, 'h96, 3, 9, 'h12);
      drain(10);

      // Random stream with random stalls on both sides
      sent = 0;
      cyc  = 0;
      acc  = 1'b0;
      while (sent < 10000 && cyc < 60000) begin
         step();
         if (!bus.in_valid || acc)
            set_in($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 7),
                   $urandom_range(0, 15), ($urandom_range(0, 3) != 0));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         sample();
         acc = bus.in_valid && bus.in_ready;
         if (acc) sent++;
         cyc++;
      end
      check("rnd_sent", 32'(sent), 32'd10000);
      step();
      drain(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dl_shift_pipe.md
Name: dl_shift_pipe

Overview:
Two-stage pipelined shift execution unit with valid/ready handshakes on both sides. It wraps the combinational barrel shifters (left logical, right logical, right arithmetic) between input and output registers. It sits between the decode/operand-read stage and the ALU writeback mux. Each operation carries a tag so the consumer can match results to instructions.

Parameters:
- NUM_BITS, 32, operand/result width; power of two, >= 4.
- NUM_SHIFT_BITS, $clog2(NUM_BITS), shift-amount width; derived, not overridden.
- TAG_BITS, 4, width of the opaque tag carried alongside each op.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream holds a valid op.
- in_ready  output  1  stage 1 can accept this cycle.
- in_op  input  2  shift_op_t: 00 SLL, 01 SRL, 10 SRA, 11 PASS.
- in_data  input  NUM_BITS  operand to shift.
- in_shamt  input  NUM_SHIFT_BITS  shift amount, 0..NUM_BITS-1.
- in_tag  input  TAG_BITS  opaque tag.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_data  output  NUM_BITS  shift result.
- out_tag  output  TAG_BITS  tag of the op that produced out_data.
- out_zero  output  1  high when out_data == 0; qualified by out_valid.

Behaviour:
- Reset: asynchronous assert. Stage 1 and stage 2 valid bits, data, shamt, op and tag registers all clear to 0. out_valid=0, out_data=0, out_tag=0, out_zero=1. in_ready is forced 0 while rst_n is low.
- Handshakes: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready. Upstream must hold in_* stable while in_valid && !in_ready. out_* stays stable while out_valid && !out_ready.
- Stage 1 captures in_op, in_data, in_shamt and in_tag on an input transfer and sets s1_valid.
- Stage 2 computes the shift combinationally from the stage 1 registers (dl_shift_core) and registers the result, tag and zero flag.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = rst_n && (!s1_valid || s2_adv). This is a combinational path from out_ready and is intentional.
- Valid updates:
  - s2_valid next = s1_adv ? 1 : (out_ready ? 0 : s2_valid).
  - s1_valid next = input transfer ? 1 : (s1_adv ? 0 : s1_valid).
- Holding: registers with no load enable hold their value.
- Latency and throughput: exactly 2 cycles from input transfer to out_valid with no backpressure; 1 op/cycle sustained.
- Ordering: strictly in order; no drop and no duplication under any out_ready pattern.
- Arithmetic:
  - SLL zero-fills from the LSB.
  - SRL zero-fills from the MSB.
  - SRA fills with in_data[NUM_BITS-1].
  - PASS returns in_data unchanged and ignores shamt.
  - shamt=0 returns in_data for every op.
  - shamt=NUM_BITS-1: SRA gives all copies of the sign bit; SRL/SLL leave a single bit.
  - out_zero is computed from the stage 2 input and registered alongside out_data.
- Simultaneous events: when full with out_ready=1 and in_valid=1, output, shift and capture all happen in one cycle.
- Reset mid-operation: in-flight ops are discarded immediately. The first op accepted after release emerges 2 cycles later.

Decomposition:
- Package dl_shift_pkg holds:
  - shift_op_t enum: SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_PASS=2'b11.
  - the width helper function for NUM_SHIFT_BITS.
- Sub-module dl_shift_core: purely combinational, parameterized by NUM_BITS, op/data/shamt in and result out. It is unit-testable on its own.
- dl_shift_pipe contains only the registers and the handshake logic.

Test Plan (NUM_BITS=8, TAG_BITS=4):
- Ops on 0x96 with shamt 3, out_ready=1, tag=5: SRA gives out_data 0xF2; SRL gives 0x12; SLL gives 0xB0; PASS gives 0x96. Each appears 2 cycles after accept with out_tag=5.
- Boundaries: SRA 0x80 shamt 7 gives 0xFF; SRL 0x80 shamt 7 gives 0x01; SLL 0x01 shamt 7 gives 0x80; SLL 0x80 shamt 1 gives 0x00 with out_zero=1; any op with shamt 0 is an identity.
- Throughput: 4 back-to-back ops, tags 1..4, out_ready=1. Tags 1..4 appear on consecutive cycles 2..5 after the first accept; in_ready stays 1 throughout.
- Backpressure: in_valid held 1, out_ready=0 for 4 cycles. Two ops are accepted, then in_ready=0 and out_* is held stable. When out_ready is released, the remaining ops drain in order with no loss or duplication.
- Reset mid-op: both stages full and out_valid=1, then rst_n pulled low between clock edges. out_valid drops to 0 immediately and in_ready=0. After release, a new op with tag 9 emerges after 2 cycles and nothing stale appears.
- Random: 10k random ops, shamts and ready/valid stalls are checked against a reference model, with a scoreboard confirming order.
